lu_arbiter: RTL and testbench
=============================

LU_ARBITER -- requirements
Module: lu_arbiter

Interface
REQ-001 Parameter WIDTH, default 4, operand/result bit width.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  2  bit i = requester i has an operation pending.
REQ-005 req_ready  output  2  bit i = requester i's operation accepted this cycle.
REQ-006 req_a  input  2*WIDTH  operand a; requester i uses bits [i*WIDTH +: WIDTH].
REQ-007 req_b  input  2*WIDTH  operand b, same packing as req_a.
REQ-008 req_op  input  2  bit i: 0 = NOR, 1 = OR (matches LU select encoding).
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_ready  input  1  consumer accepts result.
REQ-011 rsp_data  output  WIDTH  registered result.
REQ-012 rsp_id  output  1  index of requester owning rsp_data.
REQ-013 busy  output  1  high whenever state is not IDLE.

Function
REQ-014 The block SHALL share one bitwise OR/NOR logic unit between two requesters through a 3-state FSM: IDLE, EXEC, RESP.
REQ-015 IDLE: with any req_valid high, the block SHALL grant exactly one requester, assert its req_ready for that cycle only, capture its a/b/op, and move to EXEC; with none valid, it SHALL stay in IDLE.
REQ-016 Arbitration SHALL be round-robin on a last_grant flag: when both requesters are valid, the one not equal to last_grant wins; when one is valid, it wins regardless.
REQ-017 req_ready SHALL be low in EXEC and RESP; a requester holds valid and operands stable until accepted.
REQ-018 EXEC: the block SHALL compute captured a OR b (op=1) or NOR (op=0) bitwise over WIDTH bits, register it into rsp_data with rsp_id, and move to RESP.
REQ-019 RESP: rsp_valid SHALL be high and rsp_data/rsp_id stable until rsp_valid and rsp_ready are both high; then the block SHALL update last_grant to rsp_id and return to IDLE.
REQ-020 Latency: accept at cycle N SHALL give rsp_valid at N+2; minimum spacing between acceptances SHALL be 3 cycles.
REQ-021 rsp_ready high on RESP entry SHALL give a one-cycle rsp_valid pulse; rsp_ready low SHALL stall indefinitely with no new grant.
REQ-022 req_valid changes during EXEC/RESP SHALL have no effect until the next IDLE cycle.

Reset
REQ-023 rst_n low SHALL immediately force state IDLE, rsp_valid 0, rsp_data 0, rsp_id 0, last_grant 1 (requester 0 wins first tie), req_ready 0, busy 0.
REQ-024 Reset during EXEC or RESP SHALL discard the in-flight operation with no response emitted.
REQ-025 After rst_n rises, the first grant SHALL occur on the first rising edge with req_valid high.

Configuration
REQ-026 Macro LU_ARBITER_STATS_EN defined: the block SHALL add output op_count (8 bits), reset 0, incremented on each response handshake, wrapping 255 -> 0.
REQ-027 Macro LU_ARBITER_STATS_EN undefined: op_count port and counter SHALL be absent; all other behaviour is identical.

Structure
REQ-028 Shared package lu_arbiter_pkg SHALL hold the state enum (IDLE, EXEC, RESP) and op constants OP_NOR=0, OP_OR=1.
REQ-029 Logic unit SHALL be sub-module lu_core (WIDTH-bit OR and NOR, 2:1 select by op), purely combinational, instantiated once.

Verification (WIDTH=4)
REQ-030 Reset then req_valid=01, a0=0101, b0=0011, op0=1, rsp_ready=1 -> req_ready=01 at N, rsp_valid at N+2 with rsp_data=0111, rsp_id=0.
REQ-031 req_valid=10, a1=0101, b1=0011, op1=0 -> rsp_data=1000, rsp_id=1.
REQ-032 Both valid continuously after reset, rsp_ready=1 -> grants alternate 0,1,0,1, one grant every 3 cycles.
REQ-033 rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_data held, req_ready stays 00, busy=1; grant follows the handshake.
REQ-034 rst_n pulsed low during EXEC -> rsp_valid never rises for that operation, busy=0 immediately, next grant goes to requester 0.
REQ-035 With LU_ARBITER_STATS_EN, 257 completed operations -> op_count=1.

Source files
------------

// File: rtl/lu_arbiter_pkg.sv
// Shared types and constants for the two-requester OR/NOR logic-unit arbiter.
package lu_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } lu_state_e;

    localparam logic OP_NOR = 1'b0;
    localparam logic OP_OR  = 1'b1;

endpackage

// File: rtl/lu_core.sv
// Combinational bitwise logic unit: OR or NOR of two operands, selected by op.
module lu_core
    import lu_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op,
    output logic [WIDTH-1:0] y
);

    logic [WIDTH-1:0] or_res;

    always_comb begin
        or_res = a | b;
        y      = (op == OP_OR) ? or_res : ~or_res;
    end

endmodule

// File: rtl/lu_arbiter.sv
// Round-robin arbiter sharing one lu_core between two requesters (IDLE -> EXEC -> RESP).
// Optional LU_ARBITER_STATS_EN adds an 8-bit wrapping count of completed responses.
module lu_arbiter
    import lu_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [2*WIDTH-1:0] req_a,
    input  logic [2*WIDTH-1:0] req_b,
    input  logic [1:0]         req_op,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [WIDTH-1:0]   rsp_data,
    output logic               rsp_id,
    output logic               busy
`ifdef LU_ARBITER_STATS_EN
    ,
    output logic [7:0]         op_count
`endif
);

    lu_state_e        state_q, state_d;
    logic             last_grant_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic             op_q, id_q;
    logic [WIDTH-1:0] rsp_data_q;
    logic             rsp_id_q;
    logic [WIDTH-1:0] lu_y;

    logic             grant_id;
    logic             capture;
    logic             handshake;

    // With both pending the requester that did not win last time goes first.
    always_comb begin
        if (req_valid == 2'b11) begin
            grant_id = ~last_grant_q;
        end else begin
            grant_id = req_valid[1];
        end
    end

    always_comb begin
        state_d   = state_q;
        capture   = 1'b0;
        handshake = 1'b0;
        req_ready = 2'b00;
        unique case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    capture = 1'b1;
                    state_d = EXEC;
                    // Gated by rst_n so req_ready is low while reset is held.
                    if (rst_n) begin
                        req_ready = grant_id ? 2'b10 : 2'b01;
                    end
                end
            end
            EXEC: state_d = RESP;
            RESP: begin
                if (rsp_ready) begin
                    handshake = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    lu_core #(
        .WIDTH(WIDTH)
    ) u_lu_core (
        .a  (a_q),
        .b  (b_q),
        .op (op_q),
        .y  (lu_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= OP_NOR;
            id_q         <= 1'b0;
            rsp_data_q   <= '0;
            rsp_id_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                a_q  <= grant_id ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
                b_q  <= grant_id ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
                op_q <= req_op[grant_id];
                id_q <= grant_id;
            end
            if (state_q == EXEC) begin
                rsp_data_q <= lu_y;
                rsp_id_q   <= id_q;
            end
            if (handshake) begin
                last_grant_q <= rsp_id_q;
            end
        end
    end

`ifdef LU_ARBITER_STATS_EN
    logic [7:0] op_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count_q <= 8'd0;
        end else if (handshake) begin
            op_count_q <= op_count_q + 8'd1;
        end
    end

    assign op_count = op_count_q;
`endif

    assign rsp_valid = (state_q == RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_lu_arbiter.sv
// Directed self-checking bench for lu_arbiter (WIDTH=4); covers the stats counter when
// LU_ARBITER_STATS_EN is defined.
module tb_lu_arbiter;

    localparam int unsigned WIDTH = 4;

    logic               clk;
    logic               rst_n;
    logic [1:0]         req_valid;
    logic [1:0]         req_ready;
    logic [2*WIDTH-1:0] req_a;
    logic [2*WIDTH-1:0] req_b;
    logic [1:0]         req_op;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [WIDTH-1:0]   rsp_data;
    logic               rsp_id;
    logic               busy;
`ifdef LU_ARBITER_STATS_EN
    logic [7:0]         op_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    lu_arbiter #(
        .WIDTH(WIDTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .busy      (busy)
`ifdef LU_ARBITER_STATS_EN
        ,
        .op_count  (op_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called just after a negedge with the DUT in IDLE and inputs already set.
    // Checks the grant, the EXEC cycle, then RESP for stall+1 cycles (rsp_ready low for
    // the first 'stall' of them). Returns just after the negedge of the following IDLE cycle.
    task automatic txn(input logic [1:0] exp_ready, input logic [3:0] exp_data,
                       input logic exp_id, input int stall);
        #1;
        check("grant", 32'(req_ready), 32'(exp_ready));
        check("busy_idle", 32'(busy), 32'd0);
        @(negedge clk);
        check("ready_exec", 32'(req_ready), 32'd0);
        check("busy_exec", 32'(busy), 32'd1);
        check("valid_exec", 32'(rsp_valid), 32'd0);
        rsp_ready = (stall == 0);
        @(negedge clk);
        for (int i = 0; i <= stall; i++) begin
            check("valid_resp", 32'(rsp_valid), 32'd1);
            check("data_resp", 32'(rsp_data), 32'(exp_data));
            check("id_resp", 32'(rsp_id), 32'(exp_id));
            check("ready_resp", 32'(req_ready), 32'd0);
            check("busy_resp", 32'(busy), 32'd1);
            if (i == stall) rsp_ready = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 2'b11;
        req_a     = '0;
        req_b     = '0;
        req_op    = 2'b00;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_data", 32'(rsp_data), 32'd0);
        check("rst_id", 32'(rsp_id), 32'd0);
`ifdef LU_ARBITER_STATS_EN
        check("rst_count", 32'(op_count), 32'd0);
`endif
        rst_n     = 1'b1;
        req_valid = 2'b00;
        @(negedge clk);
        check("idle_ready", 32'(req_ready), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);

        // Requester 0: 0101 OR 0011 = 0111
        req_valid = 2'b01;
        req_a     = {4'b0000, 4'b0101};
        req_b     = {4'b0000, 4'b0011};
        req_op    = 2'b01;
        txn(2'b01, 4'b0111, 1'b0, 0);

        // Requester 1: 0101 NOR 0011 = 1000
        req_valid = 2'b10;
        req_a     = {4'b0101, 4'b0000};
        req_b     = {4'b0011, 4'b0000};
        req_op    = 2'b00;
        txn(2'b10, 4'b1000, 1'b1, 0);

        // Both valid after reset: 0 wins first, then alternate every 3 cycles.
        // r0: 0101 OR 0011 = 0111; r1: 1100 NOR 0001 = 0010
        pulse_reset();
        req_valid = 2'b11;
        req_a     = {4'b1100, 4'b0101};
        req_b     = {4'b0001, 4'b0011};
        req_op    = 2'b01;
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) txn(2'b01, 4'b0111, 1'b0, 0);
            else            txn(2'b10, 4'b0010, 1'b1, 0);
        end

        // Stall 5 cycles in RESP; the grant to requester 1 follows the handshake.
        txn(2'b01, 4'b0111, 1'b0, 5);
        txn(2'b10, 4'b0010, 1'b1, 0);
        txn(2'b01, 4'b0111, 1'b0, 0);

        // Reset during EXEC of requester 1's op: discarded, next grant goes to 0.
        #1;
        check("pre_rst_grant", 32'(req_ready), 32'b10);
        @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("held_rst_valid", 32'(rsp_valid), 32'd0);
        rst_n = 1'b1;
        txn(2'b01, 4'b0111, 1'b0, 0);

`ifdef LU_ARBITER_STATS_EN
        pulse_reset();
        for (int i = 0; i < 257; i++) begin
            if (i % 2 == 0) txn(2'b01, 4'b0111, 1'b0, 0);
            else            txn(2'b10, 4'b0010, 1'b1, 0);
        end
        check("op_count_wrap", 32'(op_count), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
